// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX-stage operand forwarding, load-use bubbles,
// data-memory wait holds, taken-branch flushes and saturating stall/flush counters.
module hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int LU_BUBBLES = 1,
    parameter int BR_STAGE   = 3,
    parameter int CNT_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_uses_rs_i,
    input  logic              id_uses_rt_i,
    input  logic [REG_AW-1:0] ex_rs_i,
    input  logic [REG_AW-1:0] ex_rt_i,
    input  logic              ex_memread_i,
    input  logic              mem_regwrite_i,
    input  logic [REG_AW-1:0] mem_regdst_i,
    input  logic              wb_regwrite_i,
    input  logic [REG_AW-1:0] wb_regdst_i,
    input  logic              branch_taken_i,
    input  logic              dmem_req_i,
    input  logic              dmem_ready_i,
    output logic [1:0]        forward_1_o,
    output logic [1:0]        forward_2_o,
    output logic              stall_pc_o,
    output logic              stall_if_id_o,
    output logic              hold_id_ex_o,
    output logic              hold_ex_mem_o,
    output logic              clear_if_id_o,
    output logic              clear_id_ex_o,
    output logic              clear_ex_mem_o,
    output logic              clear_mem_wb_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

    localparam logic [1:0]       LU_LOAD = 2'(LU_BUBBLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state, w_state_nxt;
    state_t           r_ret_state, w_ret_nxt;
    logic [1:0]       r_bub_cnt, w_bub_nxt;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
    logic             w_lu, w_mwait, w_flush_evt;

    assign w_lu = ex_memread_i && (ex_rt_i != '0) &&
                  ((id_uses_rs_i && (id_rs_i == ex_rt_i)) ||
                   (id_uses_rt_i && (id_rt_i == ex_rt_i)));
    assign w_mwait = dmem_req_i && !dmem_ready_i;

    // MEM result is younger than WB, so it wins; register 0 is hard-wired and never forwarded
    always_comb begin
        forward_1_o = 2'b00;
        forward_2_o = 2'b00;
        if (mem_regwrite_i && (mem_regdst_i != '0) && (mem_regdst_i == ex_rs_i))
            forward_1_o = 2'b01;
        else if (wb_regwrite_i && (wb_regdst_i != '0) && (wb_regdst_i == ex_rs_i))
            forward_1_o = 2'b10;
        if (mem_regwrite_i && (mem_regdst_i != '0) && (mem_regdst_i == ex_rt_i))
            forward_2_o = 2'b01;
        else if (wb_regwrite_i && (wb_regdst_i != '0) && (wb_regdst_i == ex_rt_i))
            forward_2_o = 2'b10;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= RUN;
            r_ret_state <= RUN;
            r_bub_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ret_state <= w_ret_nxt;
            r_bub_cnt   <= w_bub_nxt;
        end
    end

    // Priority: memory wait, then taken branch, then load-use; the release cycle of
    // a wait only honours a branch and otherwise resumes the saved state next cycle
    always_comb begin
        w_state_nxt    = r_state;
        w_ret_nxt      = r_ret_state;
        w_bub_nxt      = r_bub_cnt;
        w_flush_evt    = 1'b0;
        stall_pc_o     = 1'b0;
        stall_if_id_o  = 1'b0;
        hold_id_ex_o   = 1'b0;
        hold_ex_mem_o  = 1'b0;
        clear_if_id_o  = 1'b0;
        clear_id_ex_o  = 1'b0;
        clear_ex_mem_o = 1'b0;
        clear_mem_wb_o = 1'b0;
        if (w_mwait) begin
            stall_pc_o     = 1'b1;
            stall_if_id_o  = 1'b1;
            hold_id_ex_o   = 1'b1;
            hold_ex_mem_o  = 1'b1;
            clear_mem_wb_o = 1'b1;
            if (r_state != MEM_WAIT) begin
                w_ret_nxt   = r_state;
                w_state_nxt = MEM_WAIT;
            end
        end else if (branch_taken_i) begin
            w_flush_evt    = 1'b1;
            clear_if_id_o  = 1'b1;
            clear_id_ex_o  = 1'b1;
            clear_ex_mem_o = (BR_STAGE == 3);
            w_bub_nxt      = '0;
            w_state_nxt    = RUN;
        end else begin
            unique case (r_state)
                MEM_WAIT: w_state_nxt = r_ret_state;
                LU_STALL: begin
                    stall_pc_o    = 1'b1;
                    stall_if_id_o = 1'b1;
                    clear_id_ex_o = 1'b1;
                    w_bub_nxt     = r_bub_cnt - 2'd1;
                    if (r_bub_cnt == 2'd1)
                        w_state_nxt = RUN;
                end
                default: begin
                    if (w_lu) begin
                        stall_pc_o    = 1'b1;
                        stall_if_id_o = 1'b1;
                        clear_id_ex_o = 1'b1;
                        if (LU_BUBBLES > 1) begin
                            w_bub_nxt   = LU_LOAD;
                            w_state_nxt = LU_STALL;
                        end
                    end
                end
            endcase
        end
    end

    // Performance counters stick at all-ones instead of wrapping
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall_pc_o && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            if (w_flush_evt && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared against a pending-bubble reference model.
module tb_hazard_ctrl;

    localparam int REG_AW     = 5;
    localparam int LU_BUBBLES = 2;
    localparam int BR_STAGE   = 3;
    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       uses_rs;
        logic       uses_rt;
        logic [4:0] ex_rs;
        logic [4:0] ex_rt;
        logic       memread;
        logic       mem_rw;
        logic [4:0] mem_dst;
        logic       wb_rw;
        logic [4:0] wb_dst;
        logic       br;
        logic       req;
        logic       rdy;
    } stim_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic [REG_AW-1:0] id_rs_i = '0, id_rt_i = '0, ex_rs_i = '0, ex_rt_i = '0;
    logic [REG_AW-1:0] mem_regdst_i = '0, wb_regdst_i = '0;
    logic id_uses_rs_i = 0, id_uses_rt_i = 0, ex_memread_i = 0, mem_regwrite_i = 0;
    logic wb_regwrite_i = 0, branch_taken_i = 0, dmem_req_i = 0, dmem_ready_i = 0;
    logic [1:0] forward_1_o, forward_2_o;
    logic stall_pc_o, stall_if_id_o, hold_id_ex_o, hold_ex_mem_o;
    logic clear_if_id_o, clear_id_ex_o, clear_ex_mem_o, clear_mem_wb_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

    logic [11:0] obs;
    assign obs = {forward_1_o, forward_2_o, stall_pc_o, stall_if_id_o, hold_id_ex_o,
                  hold_ex_mem_o, clear_if_id_o, clear_id_ex_o, clear_ex_mem_o, clear_mem_wb_o};

    int tests = 0;
    int fails = 0;

    // Reference model: bubbles still owed, whether a memory wait is in progress, totals
    int m_pending = 0;
    bit m_waiting = 0;
    int m_stalls  = 0;
    int m_flushes = 0;
    logic [11:0]      exp_out;
    logic [CNT_W-1:0] exp_scnt, exp_fcnt;

    hazard_ctrl #(.REG_AW(REG_AW), .LU_BUBBLES(LU_BUBBLES), .BR_STAGE(BR_STAGE), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_uses_rs_i(id_uses_rs_i), .id_uses_rt_i(id_uses_rt_i),
        .ex_rs_i(ex_rs_i), .ex_rt_i(ex_rt_i), .ex_memread_i(ex_memread_i),
        .mem_regwrite_i(mem_regwrite_i), .mem_regdst_i(mem_regdst_i),
        .wb_regwrite_i(wb_regwrite_i), .wb_regdst_i(wb_regdst_i),
        .branch_taken_i(branch_taken_i), .dmem_req_i(dmem_req_i), .dmem_ready_i(dmem_ready_i),
        .forward_1_o(forward_1_o), .forward_2_o(forward_2_o),
        .stall_pc_o(stall_pc_o), .stall_if_id_o(stall_if_id_o),
        .hold_id_ex_o(hold_id_ex_o), .hold_ex_mem_o(hold_ex_mem_o),
        .clear_if_id_o(clear_if_id_o), .clear_id_ex_o(clear_id_ex_o),
        .clear_ex_mem_o(clear_ex_mem_o), .clear_mem_wb_o(clear_mem_wb_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [1:0] fwd(stim_t s, logic [4:0] idx);
        if (s.mem_rw && s.mem_dst != 0 && s.mem_dst == idx) return 2'b01;
        if (s.wb_rw && s.wb_dst != 0 && s.wb_dst == idx) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [CNT_W-1:0] sat(int v);
        return CNT_W'((v > CNT_MAX) ? CNT_MAX : v);
    endfunction

    function automatic stim_t s_lu();
        stim_t s = '0;
        s.memread = 1; s.ex_rt = 7; s.id_rs = 7; s.uses_rs = 1;
        return s;
    endfunction

    function automatic stim_t s_wait();
        stim_t s = '0;
        s.req = 1;
        return s;
    endfunction

    function automatic stim_t s_rand();
        stim_t s;
        s.id_rs   = 5'($urandom_range(0, 3));
        s.id_rt   = 5'($urandom_range(0, 3));
        s.uses_rs = 1'($urandom_range(0, 1));
        s.uses_rt = 1'($urandom_range(0, 1));
        s.ex_rs   = 5'($urandom_range(0, 3));
        s.ex_rt   = 5'($urandom_range(0, 3));
        s.memread = 1'($urandom_range(0, 1));
        s.mem_rw  = 1'($urandom_range(0, 1));
        s.mem_dst = 5'($urandom_range(0, 3));
        s.wb_rw   = 1'($urandom_range(0, 1));
        s.wb_dst  = 5'($urandom_range(0, 3));
        s.br      = ($urandom_range(0, 7) == 0);
        s.req     = ($urandom_range(0, 3) == 0);
        s.rdy     = 1'($urandom_range(0, 1));
        return s;
    endfunction

    function automatic void model_reset();
        m_pending = 0; m_waiting = 0; m_stalls = 0; m_flushes = 0;
    endfunction

    // Drive one cycle's inputs at the falling edge, then predict outputs and advance the model
    task automatic apply(input stim_t s);
        bit lu, stall, flush;
        @(negedge clk_i);
        id_rs_i = s.id_rs; id_rt_i = s.id_rt; id_uses_rs_i = s.uses_rs; id_uses_rt_i = s.uses_rt;
        ex_rs_i = s.ex_rs; ex_rt_i = s.ex_rt; ex_memread_i = s.memread;
        mem_regwrite_i = s.mem_rw; mem_regdst_i = s.mem_dst;
        wb_regwrite_i = s.wb_rw; wb_regdst_i = s.wb_dst;
        branch_taken_i = s.br; dmem_req_i = s.req; dmem_ready_i = s.rdy;
        #1;
        exp_scnt = sat(m_stalls);
        exp_fcnt = sat(m_flushes);
        lu = s.memread && s.ex_rt != 0 &&
             ((s.uses_rs && s.id_rs == s.ex_rt) || (s.uses_rt && s.id_rt == s.ex_rt));
        stall = 0; flush = 0;
        exp_out = {fwd(s, s.ex_rs), fwd(s, s.ex_rt), 8'b0};
        if (s.req && !s.rdy) begin
            exp_out[7:0] = 8'b1111_0001;
            stall = 1;
            m_waiting = 1;
        end else if (m_waiting) begin
            m_waiting = 0;
            if (s.br) begin flush = 1; m_pending = 0; end
        end else if (s.br) begin
            flush = 1; m_pending = 0;
        end else if (m_pending > 0) begin
            stall = 1; m_pending--;
        end else if (lu) begin
            stall = 1; m_pending = LU_BUBBLES - 1;
        end
        if (stall && !(s.req && !s.rdy)) exp_out[7:0] = 8'b1100_0100;
        if (flush) exp_out[7:0] = {4'b0000, 1'b1, 1'b1, (BR_STAGE == 3), 1'b0};
        if (stall) m_stalls++;
        if (flush) m_flushes++;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 0;
        {id_rs_i, id_rt_i, ex_rs_i, ex_rt_i, mem_regdst_i, wb_regdst_i} = '0;
        {id_uses_rs_i, id_uses_rt_i, ex_memread_i, mem_regwrite_i} = '0;
        {wb_regwrite_i, branch_taken_i, dmem_req_i, dmem_ready_i} = '0;
        model_reset();
        @(negedge clk_i);
        rst_i = 1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_i = 0;
        #1;
        tests++;
        if (obs !== 12'b0 || stall_cnt_o !== 4'd0 || flush_cnt_o !== 4'd0) begin
            fails++;
            $display("[TB] FAIL reset: outs=%b cnt=%0d/%0d expected 0 and 0/0", obs, stall_cnt_o, flush_cnt_o);
        end
        rst_i = 1;
    endtask

    task automatic test_forward();
        stim_t s = '0;
        s.mem_rw = 1; s.mem_dst = 5; s.wb_rw = 1; s.wb_dst = 5; s.ex_rs = 5; s.ex_rt = 5;
        apply(s);
        tests++;
        if (forward_1_o !== 2'b01 || obs !== exp_out) begin
            fails++;
            $display("[TB] FAIL fwd_mem_prio: fwd1=%b outs=%b expected fwd1=01 outs=%b", forward_1_o, obs, exp_out);
        end
        s.mem_dst = 0;
        apply(s);
        tests++;
        if (forward_1_o !== 2'b10 || forward_2_o !== 2'b10 || obs !== exp_out) begin
            fails++;
            $display("[TB] FAIL fwd_wb: fwd1=%b fwd2=%b expected 10/10", forward_1_o, forward_2_o);
        end
        s.wb_dst = 0; s.ex_rs = 0; s.ex_rt = 0;
        apply(s);
        tests++;
        if (forward_1_o !== 2'b00 || forward_2_o !== 2'b00) begin
            fails++;
            $display("[TB] FAIL fwd_r0: fwd1=%b fwd2=%b expected 00/00", forward_1_o, forward_2_o);
        end
    endtask

    task automatic test_load_use();
        int bubbles = 0;
        stim_t seq[4];
        do_reset();
        seq[0] = s_lu(); seq[1] = '0; seq[2] = '0; seq[3] = '0;
        foreach (seq[i]) begin
            apply(seq[i]);
            bubbles += (stall_pc_o && stall_if_id_o && clear_id_ex_o) ? 1 : 0;
            tests++;
            if (obs !== exp_out || stall_cnt_o !== exp_scnt || flush_cnt_o !== exp_fcnt) begin
                fails++;
                $display("[TB] FAIL load_use c%0d: outs=%b cnt=%0d/%0d expected outs=%b cnt=%0d/%0d",
                         i, obs, stall_cnt_o, flush_cnt_o, exp_out, exp_scnt, exp_fcnt);
            end
        end
        tests++;
        if (bubbles != 2 || stall_cnt_o !== 4'd2) begin
            fails++;
            $display("[TB] FAIL load_use_count: bubbles=%0d stall_cnt=%0d expected 2/2", bubbles, stall_cnt_o);
        end
    endtask

    task automatic test_mem_wait();
        stim_t seq[7];
        logic [6:0] stall_seen, hold_seen;
        do_reset();
        seq[0] = s_lu(); seq[1] = s_wait(); seq[2] = s_wait(); seq[3] = s_wait();
        seq[4] = '0; seq[5] = '0; seq[6] = '0;
        foreach (seq[i]) begin
            apply(seq[i]);
            stall_seen[6-i] = stall_pc_o;
            hold_seen[6-i]  = hold_id_ex_o;
            tests++;
            if (obs !== exp_out || stall_cnt_o !== exp_scnt) begin
                fails++;
                $display("[TB] FAIL mem_wait c%0d: outs=%b cnt=%0d expected outs=%b cnt=%0d",
                         i, obs, stall_cnt_o, exp_out, exp_scnt);
            end
        end
        tests++;
        if (stall_seen !== 7'b1111010 || hold_seen !== 7'b0111000) begin
            fails++;
            $display("[TB] FAIL mem_wait_pattern: stall=%b hold=%b expected 1111010/0111000", stall_seen, hold_seen);
        end
    endtask

    task automatic test_branch();
        stim_t s = s_lu();
        do_reset();
        s.br = 1;
        apply(s);
        tests++;
        if (clear_if_id_o !== 1 || clear_id_ex_o !== 1 || clear_ex_mem_o !== 1 || stall_pc_o !== 0
            || stall_if_id_o !== 0 || obs !== exp_out) begin
            fails++;
            $display("[TB] FAIL branch_lu: outs=%b expected clears 111 and no stall", obs);
        end
        apply('0);
        tests++;
        if (stall_pc_o !== 0 || clear_if_id_o !== 0 || flush_cnt_o !== 4'd1 || stall_cnt_o !== 4'd0) begin
            fails++;
            $display("[TB] FAIL branch_after: stall=%b flush_cnt=%0d stall_cnt=%0d expected 0/1/0",
                     stall_pc_o, flush_cnt_o, stall_cnt_o);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) apply(s_wait());
        apply('0);
        tests++;
        if (stall_cnt_o !== 4'd15 || stall_cnt_o !== exp_scnt) begin
            fails++;
            $display("[TB] FAIL saturation: stall_cnt=%0d expected 15", stall_cnt_o);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        apply(s_lu());
        @(negedge clk_i);
        {ex_memread_i, id_uses_rs_i, id_rs_i, ex_rt_i} = '0;
        rst_i = 0;
        #1;
        model_reset();
        tests++;
        if (obs !== 12'b0 || stall_cnt_o !== 4'd0 || flush_cnt_o !== 4'd0) begin
            fails++;
            $display("[TB] FAIL reset_mid_stall: outs=%b cnt=%0d/%0d expected 0 and 0/0",
                     obs, stall_cnt_o, flush_cnt_o);
        end
        @(negedge clk_i);
        rst_i = 1;
        apply('0);
        tests++;
        if (obs !== 12'b0 || obs !== exp_out) begin
            fails++;
            $display("[TB] FAIL reset_residual: outs=%b expected 0", obs);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            apply(s_rand());
            tests++;
            if (obs !== exp_out || stall_cnt_o !== exp_scnt || flush_cnt_o !== exp_fcnt) begin
                fails++;
                $display("[TB] FAIL random c%0d: outs=%b cnt=%0d/%0d expected outs=%b cnt=%0d/%0d",
                         i, obs, stall_cnt_o, flush_cnt_o, exp_out, exp_scnt, exp_fcnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_mem_wait();
        test_branch();
        test_saturation();
        test_reset_mid_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-index width.
REQ-002 SHALL have parameter LU_BUBBLES, default 1, legal 1..3, load-use bubble count.
REQ-003 SHALL have parameter BR_STAGE, default 3, legal 2 (EX) or 3 (MEM), branch-resolution stage.
REQ-004 SHALL have parameter CNT_W, default 32, width of each perf counter.
REQ-005 SHALL provide the ports below; one clock, reset asynchronous and active-low.
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-low reset
- id_rs_i, id_rt_i  in  REG_AW  source indices of the ID instruction
- id_uses_rs_i, id_uses_rt_i  in  1  ID instruction actually reads rs / rt
- ex_rs_i, ex_rt_i  in  REG_AW  source indices of the EX instruction
- ex_memread_i  in  1  EX instruction is a load
- mem_regwrite_i  in  1  MEM-stage regwrite
- mem_regdst_i  in  REG_AW  MEM-stage destination index
- wb_regwrite_i  in  1  WB-stage regwrite
- wb_regdst_i  in  REG_AW  WB-stage destination index
- branch_taken_i  in  1  taken branch resolved in stage BR_STAGE
- dmem_req_i, dmem_ready_i  in  1  MEM-stage data-memory request / completion
- forward_1_o, forward_2_o  out  2  00 regfile, 01 EX/MEM result, 10 WB result
- stall_pc_o, stall_if_id_o  out  1  hold PC / IF-ID register
- hold_id_ex_o, hold_ex_mem_o  out  1  hold ID-EX / EX-MEM register
- clear_if_id_o, clear_id_ex_o, clear_ex_mem_o, clear_mem_wb_o  out  1  insert bubble
- stall_cnt_o, flush_cnt_o  out  CNT_W  perf counters

Function
REQ-006 forward_1_o SHALL be 01 when mem_regwrite_i, mem_regdst_i != 0 and mem_regdst_i == ex_rs_i; else 10 when the same test holds for WB; else 00.
REQ-007 forward_2_o SHALL use the rule of REQ-006 against ex_rt_i; MEM has priority over WB.
REQ-008 Index 0 SHALL never be forwarded and SHALL never cause a load-use stall.
REQ-009 Load-use hazard (LU) SHALL be: ex_memread_i, ex_rt_i != 0, and (id_uses_rs_i and id_rs_i == ex_rt_i, or id_uses_rt_i and id_rt_i == ex_rt_i).
REQ-010 FSM states SHALL be RUN, LU_STALL, MEM_WAIT.
REQ-011 In RUN with LU: stall_pc_o, stall_if_id_o and clear_id_ex_o SHALL assert combinationally that cycle; if LU_BUBBLES > 1, load bubble counter with LU_BUBBLES-1 and go to LU_STALL.
REQ-012 In LU_STALL: assert the same three outputs and decrement the counter; return to RUN in the cycle the counter reaches 0, so total bubbles equal LU_BUBBLES exactly.
REQ-013 Memory wait SHALL be dmem_req_i and not dmem_ready_i, in any state.
- Assert stall_pc_o, stall_if_id_o, hold_id_ex_o, hold_ex_mem_o and clear_mem_wb_o.
- Deassert all other clears.
- Enter MEM_WAIT, saving the return state and the bubble counter.
REQ-014 In MEM_WAIT: remain while the wait persists; in the cycle dmem_ready_i rises, release all holds and resume the saved state next cycle with the counter unchanged.
REQ-015 Taken branch with no memory wait SHALL assert clear_if_id_o and clear_id_ex_o, plus clear_ex_mem_o when BR_STAGE == 3.
- Force stall_pc_o and stall_if_id_o low that cycle so the PC loads the target.
REQ-016 Priority SHALL be memory wait > taken branch > load-use.
- A branch during LU or LU_STALL aborts the stall: counter cleared, next state RUN.
- A branch coinciding with a memory wait is ignored; the resolving stage is held, so the branch re-presents after the wait.
REQ-017 stall_cnt_o SHALL increment once per cycle in which stall_pc_o is high.
REQ-018 flush_cnt_o SHALL increment once per cycle in which clear_if_id_o is high due to a branch.
REQ-019 Both counters SHALL saturate at all-ones and never wrap.
REQ-020 Forwarding outputs SHALL be purely combinational and independent of FSM state.

Reset
REQ-021 While rst_i is low, asynchronously force the FSM to RUN and zero the bubble counter, saved state, stall_cnt_o and flush_cnt_o.
REQ-022 rst_i low mid-stall or mid-wait SHALL drop every registered-state-derived stall, hold and clear immediately, with no residual bubble after release.

Verification
REQ-023 Forwarding:
- mem_regwrite=1, mem_regdst=5, wb_regwrite=1, wb_regdst=5, ex_rs=5 -> forward_1_o=01.
- Same inputs with mem_regdst=0 -> forward_1_o=10.
REQ-024 Load-use, LU_BUBBLES=2: ex_memread=1, ex_rt=7, id_rs=7, id_uses_rs=1 -> stall_pc_o, stall_if_id_o and clear_id_ex_o high exactly 2 cycles; stall_cnt_o +2.
REQ-025 Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles during LU_STALL -> holds high 3 cycles, then the remaining 1 bubble, then RUN.
REQ-026 Branch, BR_STAGE=3: branch_taken=1 concurrent with LU -> clears of IF-ID, ID-EX and EX-MEM high; stall_pc_o low; next state RUN; flush_cnt_o +1.
REQ-027 Saturation and reset:
- CNT_W=4, 20 stall cycles -> stall_cnt_o=15.
- rst_i low mid-LU_STALL -> all outputs 0 next cycle.
